// File: rtl/fifo_sb_checker_if.sv
`default_nettype none
// ============================================================================
// fifo_sb_checker_if : observed-FIFO signal bundle sampled by fifo_sb_checker
// Rev 1.0
// ============================================================================
interface fifo_sb_checker_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_rst_n;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output fifo_rst_n, wr_en, rd_en, data_in, data_out,
    output wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty
  );

  modport slave (
    input fifo_rst_n, wr_en, rd_en, data_in, data_out,
    input wr_ack, overflow, underflow,
    input full, empty, almostfull, almostempty
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sb_checker.sv
`default_nettype none
// ============================================================================
// fifo_sb_checker : shadow reference model and scoreboard for a sync FIFO.
// Define FIFO_CHK_DATA_EN to add model storage and data_out comparison.
// Rev 1.0
// ============================================================================
module fifo_sb_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_sb_checker_if.slave obs,
  output logic             err_valid,
  output logic [7:0]       err_mask,
  output logic [7:0]       first_err_mask,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] error_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_ZERO  = '0;
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [LVL_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             exp_wr_ack;
  logic             exp_overflow;
  logic             exp_underflow;
  logic             primed;

  logic             exp_full;
  logic             exp_empty;
  logic             exp_almostfull;
  logic             exp_almostempty;
  logic             wr_acc;
  logic             rd_acc;
  logic             compare;
  logic [7:0]       mask;

  assign exp_full        = (count == LVL_FULL);
  assign exp_almostfull  = (count == LVL_AFULL);
  assign exp_empty       = (count == LVL_ZERO);
  assign exp_almostempty = (count == LVL_ONE);

  // Full-and-empty exclusivity falls out of the level tests: an empty FIFO
  // refuses the read, a full one refuses the write.
  assign wr_acc  = obs.wr_en && !exp_full;
  assign rd_acc  = obs.rd_en && !exp_empty;
  assign compare = primed && obs.fifo_rst_n;

`ifdef FIFO_CHK_DATA_EN
  logic [FIFO_WIDTH-1:0] storage [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] exp_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_data_out <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (!obs.fifo_rst_n) begin
      exp_data_out <= '0;
    end else begin
      if (wr_acc) begin
        storage[wr_ptr] <= obs.data_in;
      end
      if (rd_acc) begin
        exp_data_out <= storage[rd_ptr];
      end
    end
  end
`else
  logic unused_data;
  assign unused_data = ^{obs.data_in, obs.data_out};
`endif

  always_comb begin
    mask    = '0;
`ifdef FIFO_CHK_DATA_EN
    mask[0] = (obs.data_out != exp_data_out);
`endif
    mask[1] = (obs.wr_ack      != exp_wr_ack);
    mask[2] = (obs.overflow    != exp_overflow);
    mask[3] = (obs.underflow   != exp_underflow);
    mask[4] = (obs.full        != exp_full);
    mask[5] = (obs.empty       != exp_empty);
    mask[6] = (obs.almostfull  != exp_almostfull);
    mask[7] = (obs.almostempty != exp_almostempty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      exp_wr_ack     <= 1'b0;
      exp_overflow   <= 1'b0;
      exp_underflow  <= 1'b0;
      primed         <= 1'b0;
      err_valid      <= 1'b0;
      err_mask       <= '0;
      first_err_mask <= '0;
      correct_cnt    <= '0;
      error_cnt      <= '0;
    end else if (!obs.fifo_rst_n) begin
      // Observed FIFO reset: model restarts, tallies survive.
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_wr_ack    <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      primed        <= 1'b0;
      err_valid     <= 1'b0;
      err_mask      <= '0;
    end else begin
      primed        <= 1'b1;
      exp_wr_ack    <= wr_acc;
      exp_overflow  <= obs.wr_en && exp_full;
      exp_underflow <= obs.rd_en && exp_empty;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase

      err_valid <= compare && (|mask);
      err_mask  <= compare ? mask : 8'h00;
      if (compare) begin
        if (|mask) begin
          if (error_cnt != '1) begin
            error_cnt <= error_cnt + CNT_ONE;
          end
          // An error mask always has a bit set, so a zero value is still unlatched.
          if (first_err_mask == 8'h00) begin
            first_err_mask <= mask;
          end
        end else if (correct_cnt != '1) begin
          correct_cnt <= correct_cnt + CNT_ONE;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fifo_sb_checker.sv
`default_nettype none
// ============================================================================
// tb_fifo_sb_checker : directed bench, a behavioural FIFO drives the checker.
// Rev 1.0
// ============================================================================
module tb_fifo_sb_checker;
`ifdef FIFO_CHK_DATA_EN
  localparam int DE = 1;
`else
  localparam int DE = 0;
`endif

  logic        clk;
  logic        rst;
  logic        inj_ov;
  logic [15:0] inj_data;

  logic        err_valid,   s_err_valid;
  logic [7:0]  err_mask,    s_err_mask;
  logic [7:0]  first_mask,  s_first_mask;
  logic [15:0] correct_cnt, error_cnt;
  logic [3:0]  s_correct_cnt, s_error_cnt;

  int checks   = 0;
  int failures = 0;

  fifo_sb_checker_if #(.FIFO_WIDTH(16)) bus ();

  fifo_sb_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .obs(bus.slave),
    .err_valid(err_valid), .err_mask(err_mask), .first_err_mask(first_mask),
    .correct_cnt(correct_cnt), .error_cnt(error_cnt)
  );

  fifo_sb_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .obs(bus.slave),
    .err_valid(s_err_valid), .err_mask(s_err_mask), .first_err_mask(s_first_mask),
    .correct_cnt(s_correct_cnt), .error_cnt(s_error_cnt)
  );

  // Behavioural observed FIFO (depth 8) with fault injection on its outputs.
  logic [15:0] f_mem [8];
  logic [3:0]  f_cnt;
  logic [2:0]  f_wp, f_rp;
  logic [15:0] f_dout;
  logic        f_ack, f_ov, f_un;

  always @(posedge clk) begin
    if (!bus.fifo_rst_n) begin
      f_cnt <= 0; f_wp <= 0; f_rp <= 0;
      f_dout <= 0; f_ack <= 0; f_ov <= 0; f_un <= 0;
    end else begin
      f_ack <= bus.wr_en && (f_cnt < 8);
      f_ov  <= bus.wr_en && (f_cnt == 8);
      f_un  <= bus.rd_en && (f_cnt == 0);
      if (bus.wr_en && f_cnt < 8) begin
        f_mem[f_wp] <= bus.data_in;
        f_wp <= f_wp + 3'd1;
      end
      if (bus.rd_en && f_cnt > 0) begin
        f_dout <= f_mem[f_rp];
        f_rp <= f_rp + 3'd1;
      end
      f_cnt <= f_cnt + {3'd0, (bus.wr_en && f_cnt < 8)} - {3'd0, (bus.rd_en && f_cnt > 0)};
    end
  end

  assign bus.data_out    = f_dout ^ inj_data;
  assign bus.wr_ack      = f_ack;
  assign bus.overflow    = f_ov ^ inj_ov;
  assign bus.underflow   = f_un;
  assign bus.full        = (f_cnt == 8);
  assign bus.almostfull  = (f_cnt == 7);
  assign bus.empty       = (f_cnt == 0);
  assign bus.almostempty = (f_cnt == 1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; inj_ov = 1'b0; inj_data = 16'h0;
    bus.fifo_rst_n = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = 16'h0;
    tick(2);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    chk("rst_first_mask", 32'(first_mask), 32'd0);
    chk("rst_correct", 32'(correct_cnt), 32'd0);
    chk("rst_error", 32'(error_cnt), 32'd0);
    chk("rst_small_error", 32'(s_error_cnt), 32'd0);

    rst = 1'b0; bus.fifo_rst_n = 1'b1;
    tick(1);
    chk("prime_no_compare", 32'(correct_cnt), 32'd0);
    tick(1);
    chk("first_compare", 32'(correct_cnt), 32'd1);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 16'(i);
      tick(1);
    end
    chk("fill_correct", 32'(correct_cnt), 32'd9);
    chk("fill_error", 32'(error_cnt), 32'd0);
    chk("fill_count", 32'(dut.count), 32'd8);
    chk("fill_full", 32'(dut.exp_full), 32'd1);

    // Write into full FIFO, then corrupt observed overflow
    bus.data_in = 16'h0009;
    tick(1);
    chk("ovf_exp", 32'(dut.exp_overflow), 32'd1);
    chk("ovf_count", 32'(dut.count), 32'd8);
    inj_ov = 1'b1;
    tick(1);
    chk("ovf_err_valid", 32'(err_valid), 32'd1);
    chk("ovf_err_mask", 32'(err_mask), 32'h04);
    chk("ovf_error_cnt", 32'(error_cnt), 32'd1);
    chk("ovf_first_mask", 32'(first_mask), 32'h04);
    chk("ovf_correct", 32'(correct_cnt), 32'd10);
    inj_ov = 1'b0; bus.wr_en = 1'b0;
    tick(1);
    chk("ovf_pulse_end", 32'(err_valid), 32'd0);
    chk("ovf_recover", 32'(correct_cnt), 32'd11);

    // Drain, underflow, simultaneous read+write while empty
    bus.rd_en = 1'b1;
    tick(8);
    tick(1);
    chk("unf_exp", 32'(dut.exp_underflow), 32'd1);
    chk("unf_correct", 32'(correct_cnt), 32'd20);
    bus.wr_en = 1'b1; bus.data_in = 16'h00A1;
    tick(1);
    chk("rw_empty_count", 32'(dut.count), 32'd1);
    chk("rw_empty_aempty", 32'(dut.exp_almostempty), 32'd1);
    chk("rw_empty_unf", 32'(dut.exp_underflow), 32'd1);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    tick(1);
    chk("rw_empty_correct", 32'(correct_cnt), 32'd22);
    chk("rw_empty_error", 32'(error_cnt), 32'd1);

    // Fill, then concurrent read/write across pointer wrap, then drain
    for (int i = 1; i <= 7; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 16'(16'h00B0 + i);
      tick(1);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 16'(16'h00C0 + i);
      tick(1);
    end
    chk("wrap_count", 32'(dut.count), 32'd7);
    bus.wr_en = 1'b0;
    tick(7);
    bus.rd_en = 1'b0;
    tick(1);
    chk("wrap_correct", 32'(correct_cnt), 32'd47);
    chk("wrap_error", 32'(error_cnt), 32'd1);
    chk("wrap_drained", 32'(dut.count), 32'd0);

    // Wrong data_out for one compare
    inj_data = 16'h0001;
    tick(1);
    chk("data_err_valid", 32'(err_valid), 32'(DE));
    chk("data_err_mask", 32'(err_mask), 32'(DE));
    chk("data_error_cnt", 32'(error_cnt), 32'(1 + DE));
    chk("data_first_kept", 32'(first_mask), 32'h04);
    inj_data = 16'h0000;
    tick(1);
    chk("data_recover", 32'(correct_cnt), 32'(49 - DE));
    chk("data_pulse_end", 32'(err_valid), 32'd0);

    // Observed FIFO reset at count 5
    for (int i = 1; i <= 5; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 16'(16'h00D0 + i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    chk("frst_pre_count", 32'(dut.count), 32'd5);
    chk("frst_pre_correct", 32'(correct_cnt), 32'(54 - DE));
    bus.fifo_rst_n = 1'b0;
    tick(1);
    chk("frst_count", 32'(dut.count), 32'd0);
    chk("frst_no_cmp0", 32'(correct_cnt), 32'(54 - DE));
    chk("frst_error_kept", 32'(error_cnt), 32'(1 + DE));
    bus.fifo_rst_n = 1'b1;
    tick(1);
    chk("frst_no_cmp1", 32'(correct_cnt), 32'(54 - DE));
    tick(1);
    chk("frst_resume", 32'(correct_cnt), 32'(55 - DE));
    chk("frst_first_kept", 32'(first_mask), 32'h04);

    // Sustained errors: 19 erroring cycles saturate the 4-bit counter
    inj_ov = 1'b1;
    tick(19);
    chk("sat_big_error", 32'(error_cnt), 32'(20 + DE));
    chk("sat_small_error", 32'(s_error_cnt), 32'd15);
    chk("sat_small_correct", 32'(s_correct_cnt), 32'd15);
    chk("sat_err_mask", 32'(err_mask), 32'h04);
    inj_ov = 1'b0;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_sb_checker.md
# fifo_sb_checker

Synthesizable shadow-model checker for the synchronous FIFO, used in emulation builds and in simulation alongside the FIFO monitor. It samples the FIFO's interface signals every cycle, runs an internal reference model of the FIFO, and compares the FIFO's registered outputs and status flags against predicted values. It reports per-cycle mismatches and keeps correct/error tallies that software or the testbench reads at end of test.

## Interface
- FIFO_WIDTH, 16, data width of the observed FIFO
- FIFO_DEPTH, 8, depth of the observed FIFO (power of two, ≥4)
- CNT_W, 16, width of the correct/error counters
---
- clk  in  1  single clock, shared with the observed FIFO
- rst  in  1  synchronous, active-high checker reset
- fifo_rst_n  in  1  observed FIFO reset, active-low
- wr_en, rd_en  in  1 each  observed FIFO controls
- data_in  in  FIFO_WIDTH  observed write data
- data_out  in  FIFO_WIDTH  observed read data
- wr_ack, overflow, underflow  in  1 each  observed registered FIFO responses
- full, empty, almostfull, almostempty  in  1 each  observed FIFO flags
- err_valid  out  1  one-cycle pulse: mismatch detected
- err_mask  out  8  mismatching fields, valid with err_valid: [0] data_out, [1] wr_ack, [2] overflow, [3] underflow, [4] full, [5] empty, [6] almostfull, [7] almostempty
- first_err_mask  out  8  sticky copy of err_mask from the first error since rst
- correct_cnt  out  CNT_W  compared cycles with no mismatch, saturating
- error_cnt  out  CNT_W  compared cycles with at least one mismatch, saturating

## Operation
- Model state: count (0..FIFO_DEPTH), wr_ptr, rd_ptr, storage array, and expected registers exp_data_out, exp_wr_ack, exp_overflow, exp_underflow.
- Each posedge, with fifo_rst_n high, the model applies the sampled wr_en/rd_en:
  - write accepted iff wr_en && count<FIFO_DEPTH, giving exp_wr_ack=1. Otherwise exp_wr_ack=0, and exp_overflow = wr_en && count==FIFO_DEPTH.
  - read accepted iff rd_en && count>0. exp_data_out becomes storage[rd_ptr], otherwise it holds its value. exp_underflow = rd_en && count==0.
  - Simultaneous accepted read and write: count unchanged. When the FIFO is empty, only the write is accepted. When it is full, only the read is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Expected flags are combinational from count: full=count==DEPTH, almostfull=count==DEPTH-1, empty=count==0, almostempty=count==1.
- Compare: each posedge, the sampled DUT outputs are checked against the current expected registers and flags, forming mask bits. If any bit is set: err_valid=1, err_mask=mask, error_cnt+1, first_err_mask latched if this is the first error. Otherwise correct_cnt+1.
- Compare happens only when primed=1 and fifo_rst_n=1. primed is cleared by rst or fifo_rst_n=0, and is set on the first clock after both are inactive.
- fifo_rst_n=0 (also mid-operation): count, pointers, and expected registers clear to 0. Storage is not cleared. Counters and first_err_mask are kept.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset (rst=1): err_valid=0, err_mask=0, first_err_mask=0, correct_cnt=0, error_cnt=0, primed=0, and all model state is cleared.
- Mismatch latency: DUT outputs sampled at posedge N produce err_valid/err_mask visible after posedge N and held for one cycle. Counters are updated at the same edge.
- Prediction: expected registers updated at posedge N correspond to DUT outputs updated at the same edge, and are compared at N+1.
- First compare happens at the second posedge after rst/fifo_rst_n are released.

## Configuration
- FIFO_CHK_DATA_EN defined: the storage array is instantiated, and data_out is compared (mask bit 0).
- Not defined: no storage, exp_data_out is absent, and mask bit 0 is tied to 0. Only control/flag behaviour is checked, for smaller emulation area.

## Test plan
- Reset, then write 0x0001..0x0008 with FIFO_DEPTH=8 → wr_ack=1 each write, full=1 after the 8th write, error_cnt=0, and correct_cnt increments every compared cycle.
- Full FIFO, wr_en=1 → exp_overflow=1, count stays 8. Then corrupt the observed overflow to 0 for one cycle → err_valid=1 one cycle later, err_mask=0x04, error_cnt=1, first_err_mask=0x04.
- Empty FIFO, rd_en=1 → exp_underflow=1. Simultaneous rd_en+wr_en while empty → only the write is accepted, count=1, almostempty=1.
- Fill the FIFO, then drain it while writing concurrently across pointer wrap → data_out sequence matches write order, and there are no errors (macro defined). Inject one wrong data_out → err_mask=0x01. Without the macro, the same injection produces no error.
- Assert fifo_rst_n=0 for one cycle with count=5 → no compare in that cycle or the next, model count=0, and counters are unchanged.
- Force 2^CNT_W+3 erroring cycles (CNT_W=4) → error_cnt holds at 15.
